// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the sequential ALU.
// Opcode values match the original combinational 8-bit ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b1110,
        OP_OR    = 4'b1101,
        OP_NOT   = 4'b1100,
        OP_XOR   = 4'b1011,
        OP_ADD   = 4'b1010,
        OP_SUB   = 4'b1001,
        OP_PASS  = 4'b1000,
        OP_ZTEST = 4'b0111,
        OP_SHL   = 4'b0110,
        OP_SHR   = 4'b0101,
        OP_ASR   = 4'b0100,
        OP_MUL   = 4'b0011
    } opcode_t;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU operations (logic, add/sub, zero test).
// Shift and multiply codes return zero here; alu_seq iterates those.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       s,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r,
    output logic             c,
    output logic             v
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (s)
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_NOT:   r = ~a;
            OP_XOR:   r = a ^ b;
            OP_PASS:  r = a;
            OP_ZTEST: r = {{(WIDTH-1){1'b0}}, (a == '0)};
            OP_ADD: begin
                r = sum[WIDTH-1:0];
                c = sum[WIDTH];
                v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            // diff[WIDTH] is the borrow out, set exactly when a < b unsigned
            OP_SUB: begin
                r = diff[WIDTH-1:0];
                c = diff[WIDTH];
                v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake; shifts run one bit per
// cycle and multiply is an unsigned shift-add over WIDTH cycles.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       s,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             c,
    output logic             v,
    output logic             z,
    output logic             n
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    state_t             state, state_nxt;
    logic [3:0]         op;
    logic [2*WIDTH-1:0] acc, acc_step;
    logic [WIDTH-1:0]   mc;
    logic [CW-1:0]      cnt;
    logic               sc, sc_step;
    logic [WIDTH:0]     mul_sum;

    logic [WIDTH-1:0]   core_r, one_r, fin_r;
    logic               core_c, core_v, one_c, one_v, fin_c;
    logic [SHW-1:0]     k;
    logic               iter_op, last_step;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .s (s),
        .a (a),
        .b (b),
        .r (core_r),
        .c (core_c),
        .v (core_v)
    );

    assign k         = b[SHW-1:0];
    assign iter_op   = (is_shift(s) && (k != '0)) || (s == OP_MUL);
    assign last_step = (cnt == CW'(1));
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // A shift by zero completes immediately with r=a and nothing shifted out
    assign one_r = is_shift(s) ? a    : core_r;
    assign one_c = is_shift(s) ? 1'b0 : core_c;
    assign one_v = is_shift(s) ? 1'b0 : core_v;

    // Multiply keeps the partial product high and the multiplier low in acc
    always_comb begin
        acc_step = acc;
        sc_step  = sc;
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mc} : {(WIDTH+1){1'b0}});
        case (op)
            OP_SHL: begin
                acc_step[WIDTH-1:0] = {acc[WIDTH-2:0], 1'b0};
                sc_step = acc[WIDTH-1];
            end
            OP_SHR: begin
                acc_step[WIDTH-1:0] = {1'b0, acc[WIDTH-1:1]};
                sc_step = acc[0];
            end
            OP_ASR: begin
                acc_step[WIDTH-1:0] = {acc[WIDTH-1], acc[WIDTH-1:1]};
                sc_step = acc[0];
            end
            OP_MUL:  acc_step = {mul_sum, acc[WIDTH-1:1]};
            default: ;
        endcase
    end

    assign fin_r = acc_step[WIDTH-1:0];
    assign fin_c = (op == OP_MUL) ? (|acc_step[2*WIDTH-1:WIDTH]) : sc_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = iter_op ? ITER : DONE;
            ITER:    if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs only change on the transition into DONE, so r never shows partial work
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r   <= '0;
            c   <= 1'b0;
            v   <= 1'b0;
            z   <= 1'b0;
            n   <= 1'b0;
            op  <= '0;
            acc <= '0;
            mc  <= '0;
            cnt <= '0;
            sc  <= 1'b0;
        end else if (state == IDLE && start) begin
            op <= s;
            if (iter_op) begin
                acc <= (s == OP_MUL) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
                mc  <= a;
                cnt <= (s == OP_MUL) ? CW'(WIDTH) : CW'(k);
                sc  <= 1'b0;
            end else begin
                r <= one_r;
                c <= one_c;
                v <= one_v;
                z <= (one_r == '0);
                n <= one_r[WIDTH-1];
            end
        end else if (state == ITER) begin
            acc <= acc_step;
            sc  <= sc_step;
            cnt <= cnt - CW'(1);
            if (last_step) begin
                r <= fin_r;
                c <= fin_c;
                v <= 1'b0;
                z <= (fin_r == '0);
                n <= fin_r[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8 and WIDTH=16.
// Vector table covers single-cycle ops, shifts and multiply; corner sequences follow.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start16;
    logic [3:0]  s8, s16;
    logic [7:0]  a8, b8, r8;
    logic [15:0] a16, b16, r16;
    logic        busy8, done8, c8, v8, z8, n8;
    logic        busy16, done16, c16, v16, z16, n16;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       c;
        logic       v;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .s(s8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .r(r8), .c(c8), .v(v8), .z(z8), .n(n8)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .s(s16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .r(r16), .c(c16), .v(v16), .z(z16), .n(n16)
    );

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Start is held for one edge, then the operand buses are scrambled
    task automatic applyStimulus(input bit wide, input logic [3:0] op,
                                 input logic [15:0] a_in, input logic [15:0] b_in);
        @(negedge clk);
        if (wide) begin
            s16 = op; a16 = a_in; b16 = b_in; start16 = 1'b1;
        end else begin
            s8 = op; a8 = a_in[7:0]; b8 = b_in[7:0]; start8 = 1'b1;
        end
        @(posedge clk);
        #1;
        start8 = 1'b0; start16 = 1'b0;
        a8 = ~a8; b8 = ~b8; a16 = ~a16; b16 = ~b16;
    endtask

    task automatic waitDone(input bit wide, output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (wide ? done16 : done8) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic runOp(input string name, input bit wide, input logic [3:0] op,
                         input logic [15:0] a_in, input logic [15:0] b_in,
                         input logic [15:0] exp_r, input logic exp_c, input logic exp_v,
                         input int exp_lat);
        int          lat;
        logic [15:0] act_r;
        logic        exp_n;
        applyStimulus(wide, op, a_in, b_in);
        waitDone(wide, lat);
        act_r = wide ? r16 : {8'h00, r8};
        exp_n = wide ? exp_r[15] : exp_r[7];
        checkOutput({name, ".lat"}, 16'(lat), 16'(exp_lat));
        checkOutput({name, ".r"}, act_r, exp_r);
        checkOutput({name, ".c"}, 16'(wide ? c16 : c8), 16'(exp_c));
        checkOutput({name, ".v"}, 16'(wide ? v16 : v8), 16'(exp_v));
        checkOutput({name, ".z"}, 16'(wide ? z16 : z8), 16'(exp_r == 16'h0));
        checkOutput({name, ".n"}, 16'(wide ? n16 : n8), 16'(exp_n));
        @(negedge clk);
        checkOutput({name, ".done_drop"}, 16'(wide ? done16 : done8), 16'h0);
        checkOutput({name, ".busy_drop"}, 16'(wide ? busy16 : busy8), 16'h0);
        checkOutput({name, ".hold"}, wide ? r16 : {8'h00, r8}, exp_r);
    endtask

    initial begin
        int lat;
        int pulses;
        logic [7:0] r_at_done;

        rst = 1'b1;
        start8 = 1'b0; start16 = 1'b0;
        s8 = '0; a8 = '0; b8 = '0;
        s16 = '0; a16 = '0; b16 = '0;

        vecs.push_back('{OP_AND,   8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0, 1});
        vecs.push_back('{OP_OR,    8'hCC, 8'hAA, 8'hEE, 1'b0, 1'b0, 1});
        vecs.push_back('{OP_NOT,   8'h0F, 8'h33, 8'hF0, 1'b0, 1'b0, 1});
        vecs.push_back('{OP_XOR,   8'hCC, 8'hAA, 8'h66, 1'b0, 1'b0, 1});
        vecs.push_back('{OP_PASS,  8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0, 1});
        vecs.push_back('{OP_ZTEST, 8'h00, 8'hFF, 8'h01, 1'b0, 1'b0, 1});
        vecs.push_back('{OP_ZTEST, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0, 1});
        vecs.push_back('{OP_ADD,   8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1});
        vecs.push_back('{OP_ADD,   8'hFF, 8'h02, 8'h01, 1'b1, 1'b0, 1});
        vecs.push_back('{OP_ADD,   8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1});
        vecs.push_back('{OP_SUB,   8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1});
        vecs.push_back('{OP_SUB,   8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1});
        vecs.push_back('{OP_SUB,   8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1});
        vecs.push_back('{OP_SHL,   8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 4});
        vecs.push_back('{OP_ASR,   8'h80, 8'h02, 8'hE0, 1'b0, 1'b0, 3});
        vecs.push_back('{OP_SHR,   8'hA5, 8'h00, 8'hA5, 1'b0, 1'b0, 1});
        vecs.push_back('{OP_SHR,   8'hA5, 8'h08, 8'hA5, 1'b0, 1'b0, 1});
        vecs.push_back('{OP_SHR,   8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 2});
        vecs.push_back('{OP_SHL,   8'h03, 8'h07, 8'h80, 1'b1, 1'b0, 8});
        vecs.push_back('{OP_ASR,   8'h7F, 8'h03, 8'h0F, 1'b1, 1'b0, 4});
        vecs.push_back('{OP_MUL,   8'h10, 8'h20, 8'h00, 1'b1, 1'b0, 9});
        vecs.push_back('{OP_MUL,   8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0, 9});
        vecs.push_back('{OP_MUL,   8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 9});
        vecs.push_back('{OP_MUL,   8'h00, 8'h55, 8'h00, 1'b0, 1'b0, 9});
        vecs.push_back('{4'b0000,  8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b1111,  8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b0001,  8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1});

        repeat (2) @(negedge clk);
        checkOutput("reset.r8", {8'h00, r8}, 16'h0);
        checkOutput("reset.flags8", {12'h0, c8, v8, z8, n8}, 16'h0);
        checkOutput("reset.hs8", {14'h0, busy8, done8}, 16'h0);
        checkOutput("reset.r16", r16, 16'h0);
        checkOutput("reset.hs16", {14'h0, busy16, done16}, 16'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            runOp($sformatf("v%0d_op%b", i, vecs[i].op), 1'b0, vecs[i].op,
                  {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, {8'h00, vecs[i].r},
                  vecs[i].c, vecs[i].v, vecs[i].lat);
        end

        runOp("w16_add", 1'b1, OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1);
        runOp("w16_shl15", 1'b1, OP_SHL, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, 16);
        runOp("w16_sub", 1'b1, OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1);
        runOp("w16_mul_ovf", 1'b1, OP_MUL, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 17);
        runOp("w16_mul", 1'b1, OP_MUL, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 1'b0, 17);

        // start still high across the DONE cycle must not launch a second op
        @(negedge clk);
        s8 = OP_ADD; a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        @(negedge clk);
        checkOutput("done_start.done", 16'(done8), 16'h1);
        checkOutput("done_start.r", {8'h00, r8}, 16'h0002);
        @(negedge clk);
        checkOutput("done_start.busy", 16'(busy8), 16'h0);
        checkOutput("done_start.done2", 16'(done8), 16'h0);
        start8 = 1'b0;

        // ADD issued mid-multiply is dropped
        applyStimulus(1'b0, OP_MUL, 16'h000F, 16'h000F);
        lat = 0;
        r_at_done = 8'h00;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 3) begin
                s8 = OP_ADD; a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
            end
            if (i == 4) start8 = 1'b0;
            if (done8 && lat == 0) begin
                lat = i;
                r_at_done = r8;
            end
        end
        start8 = 1'b0;
        checkOutput("mul_ignore.lat", 16'(lat), 16'd9);
        checkOutput("mul_ignore.r", {8'h00, r_at_done}, 16'h00E1);

        // Reset mid-multiply clears outputs at once and suppresses done
        applyStimulus(1'b0, OP_MUL, 16'h000F, 16'h000F);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_mid.busy", 16'(busy8), 16'h0);
        checkOutput("rst_mid.r", {8'h00, r8}, 16'h0);
        checkOutput("rst_mid.n", 16'(n8), 16'h0);
        checkOutput("rst_mid.done", 16'(done8), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8 || busy8) pulses++;
        end
        checkOutput("rst_mid.no_done", 16'(pulses), 16'h0);
        checkOutput("rst_mid.r_after", {8'h00, r8}, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

endmodule
